axi_snoop_stream_arbiter: RTL and testbench

AXI_SNOOP_STREAM_ARBITER -- requirements
Module: axi_snoop_stream_arbiter

---
 rtl/axi_snoop_stream_arbiter.sv | 151 +++++++++++++++
 tb/tb_axi_snoop_stream_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_snoop_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_snoop_stream_arbiter
// Purpose  : Round-robin arbiter that merges the beat streams of several AXI
//            snoop submodules (AW, W, B, AR, R) onto one AXI-Stream master.
//            Datapath is purely combinational (zero latency). The grant is
//            locked while a selected beat is stalled (HOLD) or while a
//            multi-beat burst is in flight (BURST).
// Ports    : clk, resetn          - clock, async active-low reset
//            src_valid/_last/_in_progress/_data - per-source request side
//            src_ready            - per-source beat-complete permission
//            M_AXIS_t*            - merged output stream
//            grant_id, busy       - arbitration status
//            beat_count           - saturating count of transferred beats
// Revision : 1.0 - initial release
// ============================================================================
module axi_snoop_stream_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_SRC    = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC-1:0]            src_in_progress,
    input  logic [NUM_SRC-1:0]            src_last,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic                          M_AXIS_tvalid,
    output logic [DATA_WIDTH-1:0]         M_AXIS_tdata,
    output logic                          M_AXIS_tlast,
    input  logic                          M_AXIS_tready,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          beat_count
);

    localparam int IDW = $clog2(NUM_SRC);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_HOLD  = 2'd1;
    localparam logic [1:0] c_BURST = 2'd2;

    logic [1:0]           r_state;
    logic [IDW-1:0]       r_rr_ptr;
    logic [IDW-1:0]       r_grant;
    logic [CNT_WIDTH-1:0] r_beat_count;

    logic [DATA_WIDTH-1:0] w_src_data [NUM_SRC];
    logic                  w_any_valid;
    logic [IDW-1:0]        w_pick;
    logic [IDW-1:0]        w_g;
    logic [IDW-1:0]        w_g_next;
    logic                  w_has_grant;
    logic                  w_xfer;
    logic [NUM_SRC-1:0]    w_ready;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
            assign w_src_data[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin search starting at r_rr_ptr. Walking the offsets from the
    // far end down to zero lets the nearest valid source overwrite the rest.
    always_comb begin
        w_any_valid = 1'b0;
        w_pick      = r_rr_ptr;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % NUM_SRC;
            if (src_valid[idx]) begin
                w_any_valid = 1'b1;
                w_pick      = IDW'(idx);
            end
        end
    end

    // Locked states always own a grant, even if that source's valid dropped.
    assign w_g         = (r_state == c_IDLE) ? w_pick : r_grant;
    assign w_has_grant = (r_state != c_IDLE) || w_any_valid;
    assign w_g_next    = (w_g == IDW'(NUM_SRC - 1)) ? '0 : w_g + 1'b1;

    // Outputs are forced quiet while reset is held, without waiting for a clock.
    assign M_AXIS_tvalid = resetn && w_has_grant && src_valid[w_g];
    assign M_AXIS_tdata  = w_src_data[w_g];
    assign M_AXIS_tlast  = src_last[w_g];
    assign w_xfer        = M_AXIS_tvalid && M_AXIS_tready;

    always_comb begin
        w_ready = '0;
        if (resetn && w_has_grant && M_AXIS_tready) begin
            w_ready[w_g] = 1'b1;
        end
    end

    assign src_ready  = w_ready;
    assign grant_id   = w_g;
    assign busy       = (r_state != c_IDLE);
    assign beat_count = r_beat_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_IDLE;
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_beat_count <= '0;
        end else begin
            if (w_xfer && (r_beat_count != {CNT_WIDTH{1'b1}})) begin
                r_beat_count <= r_beat_count + 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_any_valid) begin
                        if (!w_xfer) begin
                            r_state <= c_HOLD;
                            r_grant <= w_g;
                        end else if (M_AXIS_tlast && !src_in_progress[w_g]) begin
                            r_rr_ptr <= w_g_next;
                        end else begin
                            r_state <= c_BURST;
                            r_grant <= w_g;
                        end
                    end
                end
                c_HOLD: begin
                    if (w_xfer) begin
                        if (M_AXIS_tlast) begin
                            r_state  <= c_IDLE;
                            r_rr_ptr <= w_g_next;
                        end else begin
                            r_state <= c_BURST;
                        end
                    end
                end
                c_BURST: begin
                    if (w_xfer && M_AXIS_tlast) begin
                        r_state  <= c_IDLE;
                        r_rr_ptr <= w_g_next;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_snoop_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_snoop_stream_arbiter
// Purpose  : Directed self-checking bench for axi_snoop_stream_arbiter.
//            Main instance uses defaults; a second small instance
//            (CNT_WIDTH = 4) exercises beat-counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_snoop_stream_arbiter;

    localparam int DW = 128;
    localparam int NS = 5;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_in_progress;
    logic [NS-1:0]     src_last;
    logic [NS*DW-1:0]  src_data;
    logic [NS-1:0]     src_ready;
    logic              tvalid;
    logic [DW-1:0]     tdata;
    logic              tlast;
    logic              tready;
    logic [2:0]        grant_id;
    logic              busy;
    logic [CW-1:0]     beat_count;

    logic              sat_resetn;
    logic [1:0]        sat_ready;
    logic              sat_tvalid;
    logic [7:0]        sat_tdata;
    logic              sat_tlast;
    logic [0:0]        sat_grant;
    logic              sat_busy;
    logic [3:0]        sat_count;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    axi_snoop_stream_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .CNT_WIDTH(CW)) dut (
        .clk(clk), .resetn(resetn),
        .src_valid(src_valid), .src_in_progress(src_in_progress),
        .src_last(src_last), .src_data(src_data), .src_ready(src_ready),
        .M_AXIS_tvalid(tvalid), .M_AXIS_tdata(tdata), .M_AXIS_tlast(tlast),
        .M_AXIS_tready(tready), .grant_id(grant_id), .busy(busy),
        .beat_count(beat_count)
    );

    axi_snoop_stream_arbiter #(.DATA_WIDTH(8), .NUM_SRC(2), .CNT_WIDTH(4)) sat_dut (
        .clk(clk), .resetn(sat_resetn),
        .src_valid(2'b11), .src_in_progress(2'b00),
        .src_last(2'b11), .src_data(16'h2211), .src_ready(sat_ready),
        .M_AXIS_tvalid(sat_tvalid), .M_AXIS_tdata(sat_tdata), .M_AXIS_tlast(sat_tlast),
        .M_AXIS_tready(1'b1), .grant_id(sat_grant), .busy(sat_busy),
        .beat_count(sat_count)
    );

    function automatic logic [DW-1:0] exp_data(input int i);
        return {4{32'hC0DE_0000 + 32'(i)}};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        resetn          = 1'b0;
        src_valid       = '0;
        src_last        = '1;
        src_in_progress = '0;
        tready          = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        src_valid = '1;
        tready    = 1'b1;
        #1;
        checks++; if (tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
        checks++; if (src_ready !== 5'b0) begin fails++; $display("FAIL reset_ready: got %b expected 00000", src_ready); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (beat_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", beat_count); end
    endtask

    task automatic test_rr_basic();
        apply_reset();
        src_valid = 5'b00101;
        #1;
        checks++; if (grant_id !== 3'd0) begin fails++; $display("FAIL rr_c1_grant: got %0d expected 0", grant_id); end
        checks++; if (tdata !== exp_data(0)) begin fails++; $display("FAIL rr_c1_data: got %h expected %h", tdata, exp_data(0)); end
        checks++; if (src_ready !== 5'b00001) begin fails++; $display("FAIL rr_c1_ready: got %b expected 00001", src_ready); end
        @(negedge clk); #1;
        checks++; if (grant_id !== 3'd2) begin fails++; $display("FAIL rr_c2_grant: got %0d expected 2", grant_id); end
        checks++; if (tdata !== exp_data(2)) begin fails++; $display("FAIL rr_c2_data: got %h expected %h", tdata, exp_data(2)); end
        checks++; if (src_ready !== 5'b00100) begin fails++; $display("FAIL rr_c2_ready: got %b expected 00100", src_ready); end
        @(negedge clk);
        src_valid = 5'b00000;
        #1;
        checks++; if (grant_id !== 3'd3) begin fails++; $display("FAIL rr_ptr: got %0d expected 3", grant_id); end
        checks++; if (tvalid !== 1'b0) begin fails++; $display("FAIL rr_idle_tvalid: got %b expected 0", tvalid); end
        checks++; if (beat_count !== 16'd2) begin fails++; $display("FAIL rr_count: got %0d expected 2", beat_count); end
    endtask

    task automatic test_all_valid();
        apply_reset();
        src_valid = 5'b11111;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (grant_id !== 3'(i % NS)) begin
                fails++; $display("FAIL all_grant[%0d]: got %0d expected %0d", i, grant_id, i % NS);
            end
            @(negedge clk);
        end
        src_valid = '0;
        #1;
        checks++; if (beat_count !== 16'd10) begin fails++; $display("FAIL all_count: got %0d expected 10", beat_count); end
    endtask

    task automatic test_burst();
        apply_reset();
        src_valid       = 5'b01010;
        src_last        = 5'b01000;
        src_in_progress = 5'b00010;
        #1;
        checks++; if (grant_id !== 3'd1) begin fails++; $display("FAIL burst_b1_grant: got %0d expected 1", grant_id); end
        for (int b = 2; b <= 4; b++) begin
            @(negedge clk);
            if (b == 4) begin
                src_last[1]        = 1'b1;
                src_in_progress[1] = 1'b0;
            end
            #1;
            checks++; if (grant_id !== 3'd1) begin fails++; $display("FAIL burst_b%0d_grant: got %0d expected 1", b, grant_id); end
            checks++; if (busy !== 1'b1) begin fails++; $display("FAIL burst_b%0d_busy: got %b expected 1", b, busy); end
            checks++; if (src_ready !== 5'b00010) begin fails++; $display("FAIL burst_b%0d_ready: got %b expected 00010", b, src_ready); end
        end
        @(negedge clk);
        src_valid = 5'b01000;
        #1;
        checks++; if (grant_id !== 3'd3) begin fails++; $display("FAIL burst_next_grant: got %0d expected 3", grant_id); end
        checks++; if (src_ready !== 5'b01000) begin fails++; $display("FAIL burst_next_ready: got %b expected 01000", src_ready); end
        checks++; if (beat_count !== 16'd4) begin fails++; $display("FAIL burst_count: got %0d expected 4", beat_count); end
    endtask

    task automatic test_hold();
        apply_reset();
        src_valid = 5'b00100;
        tready    = 1'b0;
        #1;
        checks++; if (grant_id !== 3'd2) begin fails++; $display("FAIL hold_c1_grant: got %0d expected 2", grant_id); end
        checks++; if (src_ready !== 5'b0) begin fails++; $display("FAIL hold_c1_ready: got %b expected 00000", src_ready); end
        @(negedge clk);
        src_valid = 5'b00101;
        #1;
        checks++; if (grant_id !== 3'd2) begin fails++; $display("FAIL hold_c2_grant: got %0d expected 2", grant_id); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL hold_c2_busy: got %b expected 1", busy); end
        @(negedge clk);
        src_valid = 5'b00001;
        #1;
        checks++; if (grant_id !== 3'd2) begin fails++; $display("FAIL hold_drop_grant: got %0d expected 2", grant_id); end
        checks++; if (tvalid !== 1'b0) begin fails++; $display("FAIL hold_drop_tvalid: got %b expected 0", tvalid); end
        @(negedge clk);
        src_valid = 5'b00101;
        tready    = 1'b1;
        #1;
        checks++; if (src_ready !== 5'b00100) begin fails++; $display("FAIL hold_go_ready: got %b expected 00100", src_ready); end
        @(negedge clk); #1;
        checks++; if (grant_id !== 3'd0) begin fails++; $display("FAIL hold_after_grant: got %0d expected 0", grant_id); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL hold_after_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        src_valid       = 5'b10000;
        src_last        = 5'b00000;
        src_in_progress = 5'b10000;
        #1;
        checks++; if (grant_id !== 3'd4) begin fails++; $display("FAIL mid_b1_grant: got %0d expected 4", grant_id); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_b2_busy: got %b expected 1", busy); end
        resetn = 1'b0;
        #1;
        checks++; if (tvalid !== 1'b0) begin fails++; $display("FAIL mid_rst_tvalid: got %b expected 0", tvalid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        checks++; if (src_ready !== 5'b0) begin fails++; $display("FAIL mid_rst_ready: got %b expected 00000", src_ready); end
        @(negedge clk);
        src_valid       = 5'b10001;
        src_last        = 5'b11111;
        src_in_progress = 5'b00000;
        resetn          = 1'b1;
        #1;
        checks++; if (grant_id !== 3'd0) begin fails++; $display("FAIL mid_release_grant: got %0d expected 0", grant_id); end
        checks++; if (tvalid !== 1'b1) begin fails++; $display("FAIL mid_release_tvalid: got %b expected 1", tvalid); end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        sat_resetn = 1'b1;
        repeat (14) @(negedge clk);
        #1;
        checks++; if (sat_count !== 4'd14) begin fails++; $display("FAIL sat_14: got %0d expected 14", sat_count); end
        repeat (6) @(negedge clk);
        #1;
        checks++; if (sat_count !== 4'd15) begin fails++; $display("FAIL sat_20: got %0d expected 15", sat_count); end
    endtask

    initial begin
        resetn          = 1'b0;
        sat_resetn      = 1'b0;
        src_valid       = '0;
        src_last        = '1;
        src_in_progress = '0;
        tready          = 1'b1;
        for (int i = 0; i < NS; i++) begin
            src_data[i*DW +: DW] = exp_data(i);
        end
        #12;
        test_reset();
        test_rr_basic();
        test_all_valid();
        test_burst();
        test_hold();
        test_reset_mid_burst();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
